// File: rtl/uart_tx_pkg.sv
// uart_tx shared definitions: line states,
// line levels and default widths.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DIV_WIDTH  = 16;

  // Never let a zero divisor through.
  function automatic logic [DEF_DIV_WIDTH-1:0]
    clamp_div(input logic [DEF_DIV_WIDTH-1:0] d);
    return (d == '0) ? DEF_DIV_WIDTH'(1) : d;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// uart_tx baud generator: counts one bit period
// (or two, for a double stop bit) and ticks at its end.
// Ports:
//   clk_i, rst_i  clock, sync active-high reset
//   div_i         cycles per bit (>= 1)
//   dbl_i         period is 2*div_i when high
//   restart_i     force counter to 0 (new frame)
//   run_i         count while high, else hold at 0
//   bit_end_o     last cycle of the current period
module uart_tx_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 dbl_i,
  input  logic                 restart_i,
  input  logic                 run_i,
  output logic                 bit_end_o
);

  localparam int CW = DIV_WIDTH + 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] limit;

  // Extra bit lets one period span both stop bits.
  always_comb begin
    limit = dbl_i ? {div_i, 1'b0} - CW'(1)
                  : {1'b0, div_i} - CW'(1);
  end

  assign bit_end_o = run_i && (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !run_i) begin
      cnt_d = '0;
    end else if (bit_end_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: drains a fall-through fifo and sends
// 8N1 / 8N2 frames, LSB first, on a registered line.
// Ports:
//   clk_i, rst_i   clock, sync active-high reset
//   tx_en_i        allow new frames to start
//   baud_div_i     cycles per bit (0 acts as 1)
//   stop2_i        two stop bits when high
//   fifo_data_i    fifo head entry
//   fifo_empty_i   fifo empty flag
//   fifo_rd_en_o   one-cycle pop strobe
//   tx_o           serial line, idle high
//   busy_o         frame in progress
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tx_en_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  stop2_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(DATA_WIDTH - 1);

  uart_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic bit_end;
  logic run;
  logic dbl;
  logic last_stop;
  logic pop;

  assign run       = (state_q != ST_IDLE);
  assign dbl       = (state_q == ST_STOP) && stop2_q;
  assign last_stop = (state_q == ST_STOP) && bit_end;

  // Popping in the last stop cycle chains frames
  // back to back with no idle gap.
  assign pop = tx_en_i && !fifo_empty_i && !rst_i &&
               ((state_q == ST_IDLE) || last_stop);

  assign fifo_rd_en_o = pop;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;

  uart_tx_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .div_i     (div_q),
    .dbl_i     (dbl),
    .restart_i (pop),
    .run_i     (run),
    .bit_end_o (bit_end)
  );

  // tx_d carries the level of the state being
  // entered, so the line follows one cycle later.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    div_d   = div_q;
    stop2_d = stop2_q;
    tx_d    = tx_q;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = HIGH;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_STOP;
            tx_d    = HIGH;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          tx_d    = HIGH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = HIGH;
      end
    endcase
    if (pop) begin
      state_d = ST_START;
      shift_d = fifo_data_i;
      idx_d   = '0;
      div_d   = (baud_div_i == '0) ?
                DIV_WIDTH'(1) : baud_div_i;
      stop2_d = stop2_i;
      tx_d    = LOW;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      div_q   <= DIV_WIDTH'(1);
      stop2_q <= 1'b0;
      tx_q    <= HIGH;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame vectors plus
// back-to-back, config, reset and enable cases.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_en;
  logic [15:0] baud_div;
  logic        stop2;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        rd_en;
  logic        tx;
  logic        busy;

  uart_tx dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tx_en_i      (tx_en),
    .baud_div_i   (baud_div),
    .stop2_i      (stop2),
    .fifo_data_i  (fifo_data),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_en_o (rd_en),
    .tx_o         (tx),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pop_empty = 0;

  logic [7:0] fq[$];
  logic s_tx, s_busy, s_rd;
  logic tr_tx[0:255];
  logic tr_busy[0:255];
  logic tr_rd[0:255];

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic        stop2;
    int          deff;
    int          len;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic apply_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fq[0];
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    apply_fifo();
  endtask

  // Sample one cycle, then step into the next.
  task automatic cyc();
    @(negedge clk);
    s_tx   = tx;
    s_busy = busy;
    s_rd   = rd_en;
    if (s_rd && fifo_empty) pop_empty++;
    @(posedge clk);
    #1;
    if (s_rd && fq.size() > 0)
      void'(fq.pop_front());
    apply_fifo();
  endtask

  task automatic apply_ev(input int c,
                          input int kind,
                          input int ev);
    if (kind == 1 && c == ev) begin
      baud_div = 16'd10;
      stop2    = 1'b0;
    end
    if (kind == 2 && c == ev) tx_en = 1'b0;
    if (kind == 3 && c == ev) rst = 1'b1;
    if (kind == 3 && c == ev + 2) rst = 1'b0;
  endtask

  // Cycle 0 is the first pop; records 0..n.
  task automatic capture(input int n,
                         input int kind,
                         input int ev);
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (s_rd) begin
        found = 1;
        break;
      end
    end
    chk("pop_wait", 32'(found), 32'd1);
    tr_tx[0]   = s_tx;
    tr_busy[0] = s_busy;
    tr_rd[0]   = s_rd;
    for (int c = 1; c <= n; c++) begin
      apply_ev(c, kind, ev);
      cyc();
      tr_tx[c]   = s_tx;
      tr_busy[c] = s_busy;
      tr_rd[c]   = s_rd;
    end
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (!s_busy && !s_rd && fq.size() == 0) begin
        done = 1;
        break;
      end
    end
    chk(name, 32'(done), 32'd1);
  endtask

  function automatic int line_err(
    input logic [10:0] fr, input int div,
    input int c0, input int c1);
    int e = 0;
    for (int c = c0; c <= c1; c++)
      if (tr_tx[c] !== fr[(c - c0) / div]) e++;
    return e;
  endfunction

  function automatic int pops(input int c1);
    int p = 0;
    for (int c = 0; c <= c1; c++)
      if (tr_rd[c] === 1'b1) p++;
    return p;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int e;
    vecs[0] = '{8'hA5, 16'd4, 1'b0, 4, 40,
                11'b11_10100101_0};
    vecs[1] = '{8'h80, 16'd0, 1'b0, 1, 10,
                11'b11_10000000_0};
    vecs[2] = '{8'h3C, 16'd3, 1'b1, 3, 33,
                11'b11_00111100_0};
    vecs[3] = '{8'h00, 16'd1, 1'b1, 1, 11,
                11'b11_00000000_0};
    vecs[4] = '{8'hFF, 16'd2, 1'b0, 2, 20,
                11'b11_11111111_0};

    rst      = 1'b1;
    tx_en    = 1'b1;
    baud_div = 16'd4;
    stop2    = 1'b0;
    apply_fifo();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_tx", 32'(s_tx), 32'd1);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_rd", 32'(s_rd), 32'd0);

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (s_rd !== 1'b0 || s_tx !== 1'b1 ||
          s_busy !== 1'b0) bad++;
    end
    chk("idle_empty", 32'(bad), 32'd0);

    foreach (vecs[i]) begin
      baud_div = vecs[i].div;
      stop2    = vecs[i].stop2;
      push(vecs[i].data);
      capture(vecs[i].len + 2, 0, 0);
      e = line_err(vecs[i].frame, vecs[i].deff,
                   1, vecs[i].len);
      chk($sformatf("v%0d_line", i), 32'(e), 32'd0);
      chk($sformatf("v%0d_busy_end", i),
          {30'd0, tr_busy[vecs[i].len],
           tr_busy[vecs[i].len + 1]}, 32'd2);
      chk($sformatf("v%0d_pops", i),
          32'(pops(vecs[i].len + 2)), 32'd1);
      for (int k = 0; k < 3; k++) cyc();
    end

    baud_div = 16'd2;
    stop2    = 1'b0;
    push(8'h55);
    push(8'h0F);
    capture(42, 0, 0);
    chk("b2b_pop2_cyc", 32'(tr_rd[20]), 32'd1);
    chk("b2b_pops", 32'(pops(42)), 32'd2);
    e = line_err(11'b11_01010101_0, 2, 1, 20) +
        line_err(11'b11_00001111_0, 2, 21, 40);
    chk("b2b_line", 32'(e), 32'd0);
    chk("b2b_busy_end",
        {30'd0, tr_busy[40], tr_busy[41]}, 32'd2);

    baud_div = 16'd3;
    stop2    = 1'b1;
    push(8'hFF);
    push(8'h00);
    capture(135, 1, 10);
    chk("cfg_pop2_cyc", 32'(tr_rd[33]), 32'd1);
    chk("cfg_pops", 32'(pops(135)), 32'd2);
    e = line_err(11'b11_11111111_0, 3, 1, 33) +
        line_err(11'b11_00000000_0, 10, 34, 133);
    chk("cfg_line", 32'(e), 32'd0);
    chk("cfg_busy_end",
        {30'd0, tr_busy[133], tr_busy[134]}, 32'd2);

    baud_div = 16'd4;
    stop2    = 1'b0;
    push(8'hA5);
    push(8'h3C);
    capture(22, 3, 18);
    chk("rst_mid_rd18", 32'(tr_rd[18]), 32'd0);
    chk("rst_mid_tx", 32'(tr_tx[19]), 32'd1);
    chk("rst_mid_busy", 32'(tr_busy[19]), 32'd0);
    chk("rst_mid_rd19", 32'(tr_rd[19]), 32'd0);
    chk("rst_rel_pop", 32'(tr_rd[20]), 32'd1);
    chk("rst_rel_start", 32'(tr_tx[21]), 32'd0);
    drain("rst_drain");

    baud_div = 16'd2;
    push(8'h12);
    push(8'h34);
    capture(30, 2, 5);
    chk("en_pops", 32'(pops(30)), 32'd1);
    chk("en_busy_end",
        {30'd0, tr_busy[20], tr_busy[21]}, 32'd2);
    bad = 0;
    for (int c = 21; c <= 30; c++)
      if (tr_tx[c] !== 1'b1) bad++;
    chk("en_line_idle", 32'(bad), 32'd0);
    chk("en_queued", 32'(fq.size()), 32'd1);
    tx_en = 1'b1;
    drain("en_drain");

    chk("pop_while_empty", 32'(pop_empty), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
